mem_store_port: RTL and testbench
=================================

# mem_store_port

Memory-side store port placed directly downstream of the LSQ/circuit store stage. It accepts independent address and data handshake channels and buffers each in its own FIFO. It pairs the heads in arrival order into single-cycle write requests on a BRAM-style memory port, and tracks writes in flight. Each memory write acknowledgement is returned to the circuit as a dataless completion token.

## Interface
- DATA_TYPE, 32, store data width in bits
- ADDR_TYPE, 32, store address width in bits
- FIFO_DEPTH, 4, entries per input FIFO; power of two, ≥ 2
- MAX_PENDING, 8, cap on issued-but-undelivered writes; ≥ 1
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- dataIn  in  DATA_TYPE  store data from circuit
- dataIn_valid  in  1  data channel valid
- dataIn_ready  out  1  data channel ready
- addrIn  in  ADDR_TYPE  store address from circuit
- addrIn_valid  in  1  address channel valid
- addrIn_ready  out  1  address channel ready
- storeEn  out  1  write request to memory
- storeAddr  out  ADDR_TYPE  write address (head of address FIFO)
- storeData  out  DATA_TYPE  write data (head of data FIFO)
- storeReady  in  1  memory accepts the request this cycle
- storeAck  in  1  one-cycle pulse per completed write, in issue order
- doneOut_valid  out  1  completion token available
- doneOut_ready  in  1  circuit consumes the token

## Operation
- Two independent FIFOs, addrFifo and dataFifo, each FIFO_DEPTH deep, with read/write pointers that wrap modulo FIFO_DEPTH.
  - The full/empty distinction uses an occupancy count. Pointer equality alone is not used.
- Push: X_ready = !fullX. A push occurs on X_valid & X_ready. Channels are unrelated: either may run ahead until its FIFO is full.
- Ready depends only on the registered full flag. A full FIFO stays not-ready even in a cycle where it is popped. There is no combinational path from storeReady to the input readies.
- Issue: storeEn = !emptyAddr & !emptyData & (pending + doneCount < MAX_PENDING).
  - storeAddr and storeData are the FIFO heads.
  - Accept = storeEn & storeReady; on accept, both FIFOs pop.
  - While storeEn & !storeReady, storeEn, storeAddr and storeData are held stable.
- Counters are each clog2(MAX_PENDING+1) bits wide:
  - pending: +1 on accept, −1 on a counted ack. Accept and ack in the same cycle leaves it unchanged.
  - doneCount: +1 on a counted ack, −1 on doneOut_valid & doneOut_ready. Both in the same cycle leaves it unchanged.
  - A counted ack is storeAck & (pending != 0). storeAck with pending == 0 is a protocol error: it is ignored and neither counter changes.
  - Invariant: pending + doneCount ≤ MAX_PENDING. Neither counter can overflow.
- doneOut_valid = (doneCount != 0). Tokens are dataless and in order.
- Reset, whether at power-up or mid-operation, clears both FIFOs, pending and doneCount. Buffered entries and in-flight tracking are discarded.
  - While rst is high: dataIn_ready = 0, addrIn_ready = 0, storeEn = 0, doneOut_valid = 0.
  - storeAddr and storeData are don't-care whenever storeEn = 0.
  - Acks arriving after reset for writes issued before it are ignored, per the pending == 0 rule.

## Timing
- Cycle after rst deasserts: both readies = 1, storeEn = 0, doneOut_valid = 0.
- Input latency: address and data pushed in cycle t give storeEn = 1 in cycle t+1. There is no same-cycle bypass.
- Throughput: one write per cycle sustained, as long as storeReady = 1, both FIFOs are non-empty, and the pending cap is not reached.
- storeAck in cycle t gives doneOut_valid = 1 in cycle t+1, with doneOut_valid driven from the registered doneCount.
- Boundary conditions:
  - When the cap is reached, storeEn drops in the same cycle that the sum reaches MAX_PENDING.
  - storeEn reasserts the cycle after a token handshake lowers the sum.
  - FIFO full: the push side stalls; the pop still completes that cycle; ready returns the next cycle.

## Test plan
- Single store: addrIn = 0x10 and dataIn = 0xDEADBEEF together, storeReady = 1, ack 3 cycles after the accept.
  - Required: storeEn for exactly 1 cycle carrying 0x10/0xDEADBEEF, then doneOut_valid 1 cycle after the ack.
- Skewed channels: 4 data words 1..4 sent, with no addresses for 10 cycles.
  - Required: dataIn_ready = 0 after the 4th push and storeEn stays 0.
  - Then addresses A0..A3 are sent; required: 4 consecutive writes pairing (A0,1)…(A3,4).
- Memory backpressure: storeReady = 0 for 5 cycles with a request pending.
  - Required: storeEn, storeAddr and storeData are held constant, no pop occurs, and the write is accepted on the first cycle storeReady = 1.
- Pending cap: MAX_PENDING = 8, no acks, doneOut_ready = 0, 12 stores offered.
  - Required: exactly 8 accepts, then storeEn = 0.
  - Then 1 ack and 1 token handshake; required: exactly 1 further accept.
- Simultaneous events: an accept and an ack in the same cycle leave pending unchanged. An ack and a token handshake in the same cycle leave doneCount unchanged. A spurious storeAck with pending = 0 produces no token.
- Reset mid-operation: rst asserted with 3 entries buffered and 2 writes pending.
  - Required: after release, both readies = 1, storeEn = 0, no tokens.
  - Late acks for the 2 pre-reset writes produce no tokens.

Source files
------------

// File: rtl/mem_store_port.sv
// Store port: buffers independent address/data channels, pairs them into
// BRAM writes and returns one dataless completion token per acknowledged write.
module mem_store_port #(
  parameter int DATA_TYPE   = 32,
  parameter int ADDR_TYPE   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_PENDING = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] dataIn,
  input  logic                 dataIn_valid,
  output logic                 dataIn_ready,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic                 storeEn,
  output logic [ADDR_TYPE-1:0] storeAddr,
  output logic [DATA_TYPE-1:0] storeData,
  input  logic                 storeReady,
  input  logic                 storeAck,
  output logic                 doneOut_valid,
  input  logic                 doneOut_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [ADDR_TYPE-1:0] amem [FIFO_DEPTH];
  logic [DATA_TYPE-1:0] dmem [FIFO_DEPTH];

  logic [PW-1:0] awp, arp, dwp, drp;
  logic [PW:0]   acnt, dcnt;
  logic [CW-1:0] pending, done_cnt;
  logic [CW:0]   inflight;

  logic afull, dfull, aempty, dempty;
  logic apush, dpush, accept;
  logic ack_ok, tok;
  logic cap_ok;

  assign afull  = (acnt == (PW+1)'(FIFO_DEPTH));
  assign dfull  = (dcnt == (PW+1)'(FIFO_DEPTH));
  assign aempty = (acnt == '0);
  assign dempty = (dcnt == '0);

  // Readies come from registered occupancy only, never from the pop side.
  assign addrIn_ready = !afull & !rst;
  assign dataIn_ready = !dfull & !rst;

  assign apush = addrIn_valid & addrIn_ready;
  assign dpush = dataIn_valid & dataIn_ready;

  assign inflight = {1'b0, pending} + {1'b0, done_cnt};
  assign cap_ok   = (inflight < (CW+1)'(MAX_PENDING));

  assign storeEn   = !aempty & !dempty & cap_ok & !rst;
  assign storeAddr = amem[arp];
  assign storeData = dmem[drp];
  assign accept    = storeEn & storeReady;

  // Acks with nothing in flight (e.g. for writes issued before reset) are dropped.
  assign ack_ok        = storeAck & (pending != '0) & !rst;
  assign doneOut_valid = (done_cnt != '0) & !rst;
  assign tok           = doneOut_valid & doneOut_ready;

  always_ff @(posedge clk) begin
    if (apush) amem[awp] <= addrIn;
    if (dpush) dmem[dwp] <= dataIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awp <= '0;
      arp <= '0;
      acnt <= '0;
    end else begin
      if (apush) awp <= awp + 1'b1;
      if (accept) arp <= arp + 1'b1;
      unique case ({apush, accept})
        2'b10:   acnt <= acnt + 1'b1;
        2'b01:   acnt <= acnt - 1'b1;
        default: acnt <= acnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwp <= '0;
      drp <= '0;
      dcnt <= '0;
    end else begin
      if (dpush) dwp <= dwp + 1'b1;
      if (accept) drp <= drp + 1'b1;
      unique case ({dpush, accept})
        2'b10:   dcnt <= dcnt + 1'b1;
        2'b01:   dcnt <= dcnt - 1'b1;
        default: dcnt <= dcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      done_cnt <= '0;
    end else begin
      unique case ({accept, ack_ok})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      unique case ({ack_ok, tok})
        2'b10:   done_cnt <= done_cnt + 1'b1;
        2'b01:   done_cnt <= done_cnt - 1'b1;
        default: done_cnt <= done_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_port.sv
// Bench for mem_store_port: directed scenarios plus random traffic,
// checked by a queue-based scoreboard/model sampled on the falling edge.
module tb_mem_store_port;

  localparam int D    = 4;
  localparam int MAXP = 8;

  logic        clk = 0;
  logic        rst;
  logic [31:0] dataIn, addrIn;
  logic        dataIn_valid, addrIn_valid;
  logic        dataIn_ready, addrIn_ready;
  logic        storeEn;
  logic [31:0] storeAddr, storeData;
  logic        storeReady, storeAck;
  logic        doneOut_valid, doneOut_ready;

  mem_store_port #(
    .DATA_TYPE(32), .ADDR_TYPE(32),
    .FIFO_DEPTH(D), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst(rst),
    .dataIn(dataIn), .dataIn_valid(dataIn_valid),
    .dataIn_ready(dataIn_ready),
    .addrIn(addrIn), .addrIn_valid(addrIn_valid),
    .addrIn_ready(addrIn_ready),
    .storeEn(storeEn), .storeAddr(storeAddr),
    .storeData(storeData), .storeReady(storeReady),
    .storeAck(storeAck),
    .doneOut_valid(doneOut_valid),
    .doneOut_ready(doneOut_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int tok_cnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: contents of each channel buffer and in-flight counts.
  logic [31:0] m_a[$];
  logic [31:0] m_d[$];
  int m_p = 0;
  int m_dn = 0;
  bit hold_prev = 0;
  logic [31:0] prev_a, prev_d;

  always @(negedge clk) begin
    bit ra, rd, en, acc, cack, tk;
    if (rst) begin
      chk("rst_addr_ready", addrIn_ready, 0);
      chk("rst_data_ready", dataIn_ready, 0);
      chk("rst_store_en", storeEn, 0);
      chk("rst_done_valid", doneOut_valid, 0);
      m_a.delete();
      m_d.delete();
      m_p = 0;
      m_dn = 0;
      hold_prev = 0;
    end else begin
      ra = m_a.size() < D;
      rd = m_d.size() < D;
      en = m_a.size() > 0 && m_d.size() > 0 && (m_p + m_dn) < MAXP;
      chk("addr_ready", addrIn_ready, ra);
      chk("data_ready", dataIn_ready, rd);
      chk("store_en", storeEn, en);
      chk("done_valid", doneOut_valid, m_dn != 0);
      if (hold_prev) begin
        chk("hold_en", storeEn, 1);
        chk("hold_addr", storeAddr, prev_a);
        chk("hold_data", storeData, prev_d);
      end
      acc = en && storeReady;
      if (acc) begin
        chk("wr_addr", storeAddr, m_a[0]);
        chk("wr_data", storeData, m_d[0]);
        void'(m_a.pop_front());
        void'(m_d.pop_front());
      end
      if (storeEn && storeReady) acc_cnt++;
      if (doneOut_valid && doneOut_ready) tok_cnt++;
      hold_prev = storeEn && !storeReady;
      prev_a = storeAddr;
      prev_d = storeData;
      if (addrIn_valid && ra) m_a.push_back(addrIn);
      if (dataIn_valid && rd) m_d.push_back(dataIn);
      cack = storeAck && m_p != 0;
      tk = m_dn != 0 && doneOut_ready;
      m_p = m_p + int'(acc) - int'(cack);
      m_dn = m_dn + int'(cack) - int'(tk);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    addrIn_valid = 0;
    dataIn_valid = 0;
    storeAck = 0;
    storeReady = 0;
    doneOut_ready = 0;
    step(2);
    rst = 0;
  endtask

  task automatic push(input bit ua, input bit ud,
                      input logic [31:0] a,
                      input logic [31:0] d);
    bit da, dd;
    int n;
    da = !ua;
    dd = !ud;
    n = 0;
    addrIn = a;
    dataIn = d;
    addrIn_valid = ua;
    dataIn_valid = ud;
    while (!(da && dd) && n < 100) begin
      @(negedge clk);
      if (addrIn_valid && addrIn_ready) da = 1;
      if (dataIn_valid && dataIn_ready) dd = 1;
      step();
      if (da) addrIn_valid = 0;
      if (dd) dataIn_valid = 0;
      n++;
    end
    if (n >= 100) chk("push_timeout", 1, 0);
  endtask

  int a0;

  initial begin
    rst = 1;
    addrIn = 0;
    dataIn = 0;
    addrIn_valid = 0;
    dataIn_valid = 0;
    storeReady = 0;
    storeAck = 0;
    doneOut_ready = 0;

    // single store
    do_reset();
    @(negedge clk);
    chk("post_rst_addr_ready", addrIn_ready, 1);
    chk("post_rst_data_ready", dataIn_ready, 1);
    step();
    storeReady = 1;
    a0 = acc_cnt;
    push(1, 1, 32'h10, 32'hDEADBEEF);
    step();
    storeReady = 0;
    chk("single_accepts", acc_cnt - a0, 1);
    step(2);
    storeAck = 1;
    step();
    storeAck = 0;
    chk("single_done_valid", doneOut_valid, 1);
    a0 = tok_cnt;
    doneOut_ready = 1;
    step(2);
    doneOut_ready = 0;
    chk("single_tokens", tok_cnt - a0, 1);

    // skewed channels
    do_reset();
    storeReady = 1;
    a0 = acc_cnt;
    for (int i = 1; i <= 4; i++) push(0, 1, 0, i);
    chk("skew_data_full", dataIn_ready, 0);
    step(10);
    chk("skew_no_write", acc_cnt - a0, 0);
    for (int i = 0; i < 4; i++) push(1, 0, 32'h100 + 4 * i, 0);
    step(3);
    chk("skew_writes", acc_cnt - a0, 4);

    // memory backpressure
    do_reset();
    storeReady = 0;
    a0 = acc_cnt;
    push(1, 1, 32'h20, 32'h55AA);
    step(5);
    chk("bp_no_accept", acc_cnt - a0, 0);
    storeReady = 1;
    step();
    storeReady = 0;
    chk("bp_accept", acc_cnt - a0, 1);

    // pending cap
    do_reset();
    storeReady = 1;
    a0 = acc_cnt;
    for (int i = 0; i < 12; i++) push(1, 1, 32'h200 + i, 32'h1000 + i);
    step(3);
    chk("cap_accepts", acc_cnt - a0, 8);
    chk("cap_en_low", storeEn, 0);
    storeAck = 1;
    step();
    storeAck = 0;
    doneOut_ready = 1;
    step();
    doneOut_ready = 0;
    step(3);
    chk("cap_one_more", acc_cnt - a0, 9);
    // ack alone, then ack+token, then ack while an accept fires
    storeAck = 1;
    step();
    doneOut_ready = 1;
    step();
    doneOut_ready = 0;
    step();
    storeAck = 0;
    step(3);
    chk("cap_after_mix", acc_cnt - a0, 10);

    // spurious ack
    do_reset();
    a0 = tok_cnt;
    storeAck = 1;
    step();
    storeAck = 0;
    doneOut_ready = 1;
    step(2);
    doneOut_ready = 0;
    chk("spurious_tokens", tok_cnt - a0, 0);

    // reset mid-operation
    do_reset();
    storeReady = 1;
    push(1, 1, 32'h300, 32'h1);
    push(1, 1, 32'h304, 32'h2);
    step();
    storeReady = 0;
    for (int i = 0; i < 3; i++) push(1, 1, 32'h308 + 4 * i, 3 + i);
    do_reset();
    @(negedge clk);
    chk("mid_rst_addr_ready", addrIn_ready, 1);
    chk("mid_rst_data_ready", dataIn_ready, 1);
    chk("mid_rst_en", storeEn, 0);
    chk("mid_rst_done", doneOut_valid, 0);
    step();
    a0 = tok_cnt;
    doneOut_ready = 1;
    storeAck = 1;
    step(2);
    storeAck = 0;
    step(2);
    doneOut_ready = 0;
    chk("late_ack_tokens", tok_cnt - a0, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      addrIn = $urandom;
      dataIn = $urandom;
      addrIn_valid = ($urandom % 3) != 0;
      dataIn_valid = ($urandom % 3) != 0;
      storeReady = ($urandom % 4) != 0;
      storeAck = ($urandom % 3) == 0;
      doneOut_ready = ($urandom % 2) == 0;
      rst = ($urandom % 500) == 0;
      step();
    end
    rst = 0;
    addrIn_valid = 0;
    dataIn_valid = 0;
    storeAck = 0;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
